// File: rtl/multi_timer_if.sv
// Bus bundle for multi_timer: per-channel control inputs and registered status outputs.
// pause_i exists only when MULTI_TIMER_PAUSE_EN is defined.
interface multi_timer_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]       start_i;
    logic [CHANNELS-1:0]       stop_i;
    logic [CHANNELS-1:0]       periodic_i;
    logic [CHANNELS*WIDTH-1:0] n_i;
`ifdef MULTI_TIMER_PAUSE_EN
    logic [CHANNELS-1:0]       pause_i;
`endif
    logic [CHANNELS*WIDTH-1:0] curr_time_q;
    logic [CHANNELS-1:0]       curr_end_q;
    logic [CHANNELS-1:0]       busy_q;
    logic                      any_end_q;

    modport master (
        output start_i, stop_i, periodic_i, n_i,
`ifdef MULTI_TIMER_PAUSE_EN
        output pause_i,
`endif
        input  curr_time_q, curr_end_q, busy_q, any_end_q
    );

    modport slave (
        input  start_i, stop_i, periodic_i, n_i,
`ifdef MULTI_TIMER_PAUSE_EN
        input  pause_i,
`endif
        output curr_time_q, curr_end_q, busy_q, any_end_q
    );
endinterface

// File: rtl/multi_timer.sv
// Multi-channel up-counting timer with one-shot / periodic modes and per-channel stop.
// Optional per-channel pause input is enabled by defining MULTI_TIMER_PAUSE_EN.
module multi_timer #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic           clk,
    input  logic           rst,
    multi_timer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t           state;
        logic [WIDTH-1:0] limit;
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] count_inc;
        logic [WIDTH-1:0] n_c;
        logic             mode;
        logic             end_q;
        logic             busy;
        logic             pause;

        assign n_c       = bus.n_i[c*WIDTH +: WIDTH];
        assign count_inc = count + WIDTH'(1);
`ifdef MULTI_TIMER_PAUSE_EN
        assign pause     = bus.pause_i[c];
`else
        assign pause     = 1'b0;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= IDLE;
                limit <= '0;
                mode  <= 1'b0;
                count <= '0;
                end_q <= 1'b0;
                busy  <= 1'b0;
            end else if (bus.stop_i[c]) begin
                state <= IDLE;
                count <= '0;
                end_q <= 1'b0;
                busy  <= 1'b0;
            end else if (bus.start_i[c]) begin
                limit <= n_c;
                mode  <= bus.periodic_i[c];
                count <= '0;
                // A zero terminal count completes on the start edge itself.
                if (n_c == '0) begin
                    end_q <= 1'b1;
                    state <= bus.periodic_i[c] ? RUN : DONE;
                    busy  <= bus.periodic_i[c];
                end else begin
                    end_q <= 1'b0;
                    state <= RUN;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (pause) begin
                            end_q <= 1'b0;
                        end else if (count == limit) begin
                            // Only periodic channels sit in RUN at the limit: wrap.
                            count <= '0;
                            end_q <= (limit == '0);
                        end else begin
                            count <= count_inc;
                            end_q <= (count_inc == limit);
                            if (count_inc == limit && !mode) begin
                                state <= DONE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: end_q <= 1'b0;
                endcase
            end
        end

        assign bus.curr_time_q[c*WIDTH +: WIDTH] = count;
        assign bus.curr_end_q[c]                 = end_q;
        assign bus.busy_q[c]                     = busy;
    end

    assign bus.any_end_q = |bus.curr_end_q;
endmodule

// File: tb/tb_multi_timer.sv
// Randomized and directed bench for multi_timer, checked against an elapsed-time reference model.
// A second 4-bit, single-channel instance exercises the all-ones terminal count.
module tb_multi_timer;
    localparam int W  = 16;
    localparam int CH = 4;
    localparam int NM = CH + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_timer_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
    multi_timer_if #(.WIDTH(4), .CHANNELS(1))  bus4 ();

    multi_timer #(.WIDTH(W), .CHANNELS(CH)) dut   (.clk(clk), .rst(rst), .bus(bus));
    multi_timer #(.WIDTH(4), .CHANNELS(1))  dut_4 (.clk(clk), .rst(rst), .bus(bus4));

    int num_checks = 0;
    int num_fails  = 0;

    // Stimulus for channels 0..3 of the wide instance plus channel 4 = the 4-bit instance.
    logic [NM-1:0] st, sp, pr, pa;
    int            nv [NM];

    // Model: a channel is either inactive or has run for t unpaused cycles since its start.
    bit m_act [NM];
    bit m_per [NM];
    bit m_hold[NM];
    int m_t   [NM];
    int m_lim [NM];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int exp_count(int c);
        if (!m_act[c]) return 0;
        if (m_per[c]) return m_t[c];
        return (m_t[c] < m_lim[c]) ? m_t[c] : m_lim[c];
    endfunction

    function automatic bit exp_end(int c);
        return m_act[c] && !m_hold[c] && (m_t[c] == m_lim[c]);
    endfunction

    function automatic bit exp_busy(int c);
        return m_act[c] && (m_per[c] || m_t[c] < m_lim[c]);
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NM; c++) begin
            m_act[c] = 0; m_per[c] = 0; m_hold[c] = 0; m_t[c] = 0; m_lim[c] = 0;
        end
    endfunction

    function automatic void model_step();
        for (int c = 0; c < NM; c++) begin
            m_hold[c] = 0;
            if (sp[c]) begin
                m_act[c] = 0;
            end else if (st[c]) begin
                m_act[c] = 1;
                m_t[c]   = 0;
                m_per[c] = pr[c];
                m_lim[c] = (c == CH) ? (nv[c] & 15) : (nv[c] & 16'hFFFF);
            end else if (m_act[c]) begin
                if (exp_busy(c) && pa[c]) m_hold[c] = 1;
                else if (m_per[c]) m_t[c] = (m_t[c] == m_lim[c]) ? 0 : m_t[c] + 1;
                else if (m_t[c] <= m_lim[c]) m_t[c]++;
            end
        end
    endfunction

    task automatic check_all();
        bit any_exp;
        any_exp = 0;
        for (int c = 0; c < CH; c++) begin
            checkOutput($sformatf("count%0d", c), 32'(bus.curr_time_q[c*W +: W]), 32'(exp_count(c)));
            checkOutput($sformatf("end%0d", c),   32'(bus.curr_end_q[c]),         32'(exp_end(c)));
            checkOutput($sformatf("busy%0d", c),  32'(bus.busy_q[c]),             32'(exp_busy(c)));
            any_exp |= exp_end(c);
        end
        checkOutput("any_end",   32'(bus.any_end_q),   32'(any_exp));
        checkOutput("count_w4",  32'(bus4.curr_time_q), 32'(exp_count(CH)));
        checkOutput("end_w4",    32'(bus4.curr_end_q),  32'(exp_end(CH)));
        checkOutput("busy_w4",   32'(bus4.busy_q),      32'(exp_busy(CH)));
        checkOutput("any_end_w4", 32'(bus4.any_end_q),  32'(exp_end(CH)));
    endtask

    task automatic applyStimulus();
        bus.start_i    = st[CH-1:0];
        bus.stop_i     = sp[CH-1:0];
        bus.periodic_i = pr[CH-1:0];
        for (int c = 0; c < CH; c++) bus.n_i[c*W +: W] = 16'(nv[c]);
        bus4.start_i    = st[CH];
        bus4.stop_i     = sp[CH];
        bus4.periodic_i = pr[CH];
        bus4.n_i        = 4'(nv[CH]);
`ifdef MULTI_TIMER_PAUSE_EN
        bus.pause_i  = pa[CH-1:0];
        bus4.pause_i = pa[CH];
`endif
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic quiet(input int cycles);
        st = '0; sp = '0; pa = '0;
        repeat (cycles) applyStimulus();
    endtask

    initial begin
        st = '0; sp = '0; pr = '0; pa = '0;
        for (int c = 0; c < NM; c++) nv[c] = 0;
        model_reset();
        rst = 1'b1;
        bus.start_i = '0; bus.stop_i = '0; bus.periodic_i = '0; bus.n_i = '0;
        bus4.start_i = '0; bus4.stop_i = '0; bus4.periodic_i = '0; bus4.n_i = '0;
`ifdef MULTI_TIMER_PAUSE_EN
        bus.pause_i = '0; bus4.pause_i = '0;
`endif
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        quiet(2);

        $display("[TB] one-shot ch0 N=20");
        st = 5'b00001; pr = '0; nv[0] = 20;
        applyStimulus();
        quiet(24);
        checkOutput("oneshot_hold", 32'(bus.curr_time_q[W-1:0]), 32'd20);

        $display("[TB] periodic ch1 N=3 with one-shot ch2 N=5");
        st = 5'b00110; pr = 5'b00010; nv[1] = 3; nv[2] = 5;
        applyStimulus();
        quiet(14);

        $display("[TB] restart ch0 at count 7 with N=2");
        st = 5'b00001; pr = '0; nv[0] = 10;
        applyStimulus();
        quiet(7);
        st = 5'b00001; nv[0] = 2;
        applyStimulus();
        quiet(4);

        $display("[TB] start and stop together on ch3");
        st = 5'b01000; sp = 5'b01000; nv[3] = 4;
        applyStimulus();
        quiet(2);
        checkOutput("startstop_busy", 32'(bus.busy_q[3]), 32'd0);

        $display("[TB] N=0 one-shot ch0, N=0 periodic ch1");
        st = 5'b00011; pr = 5'b00010; nv[0] = 0; nv[1] = 0;
        applyStimulus();
        quiet(5);
        sp = 5'b00010;
        applyStimulus();
        quiet(1);

        $display("[TB] 4-bit channel N=15");
        st = 5'b10000; pr = '0; nv[4] = 15;
        applyStimulus();
        quiet(20);
        checkOutput("w4_no_wrap", 32'(bus4.curr_time_q), 32'd15);

        $display("[TB] reset mid-count");
        st = 5'b00001; pr = '0; nv[0] = 20;
        applyStimulus();
        quiet(8);
        rst = 1'b1;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        quiet(4);

`ifdef MULTI_TIMER_PAUSE_EN
        $display("[TB] pause ch0 at count 4");
        st = 5'b00001; pr = '0; nv[0] = 10;
        applyStimulus();
        quiet(4);
        pa = 5'b00001;
        repeat (3) applyStimulus();
        quiet(8);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NM; c++) begin
                st[c] = ($urandom_range(0, 15) == 0);
                sp[c] = ($urandom_range(0, 63) == 0);
                pr[c] = 1'($urandom_range(0, 1));
                nv[c] = ($urandom_range(0, 31) == 0) ? int'($urandom_range(0, 65535))
                                                     : int'($urandom_range(0, 25));
`ifdef MULTI_TIMER_PAUSE_EN
                pa[c] = ($urandom_range(0, 7) == 0);
`endif
            end
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end
endmodule
